// File: rtl/slave_reply_scheduler.sv
// Round-robin request arbiter with credit limiting against a fixed-depth dest-tag queue.
// Forwards the winning request to the slave and pushes its return routing for the reply path.
module slave_reply_scheduler #(
  parameter int unsigned N_REQ            = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned TAG_WIDTH        = 8,
  parameter int unsigned MAX_OUTSTANDING  = 12
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       i_req_valid,
  output logic [N_REQ-1:0]                       i_req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]            i_req_data,
  input  logic [N_REQ*ADDRESS_WIDTH-1:0]         i_req_dst,
  input  logic [N_REQ*VC_ADDRESS_WIDTH-1:0]      i_req_vc,
  input  logic [N_REQ*TAG_WIDTH-1:0]             i_req_tag,
  output logic                                   o_slv_valid,
  output logic [DATA_WIDTH-1:0]                  o_slv_data,
  output logic                                   o_tq_push,
  output logic [ADDRESS_WIDTH-1:0]               o_tq_dst,
  output logic [VC_ADDRESS_WIDTH-1:0]            o_tq_vc,
  output logic [TAG_WIDTH-1:0]                   o_tq_tag,
  input  logic                                   i_slv_reply_valid,
  output logic                                   o_tq_pop,
  input  logic                                   i_flush,
  output logic                                   o_flush_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding,
  output logic                                   o_err_underflow
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {StRun, StDrain} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_outstanding;

  logic                        w_can_grant;
  logic                        w_found;
  logic [PTR_W-1:0]            w_idx;
  logic                        w_accept;
  logic [DATA_WIDTH-1:0]       w_data;
  logic [ADDRESS_WIDTH-1:0]    w_dst;
  logic [VC_ADDRESS_WIDTH-1:0] w_vc;
  logic [TAG_WIDTH-1:0]        w_tag;

  assign w_can_grant   = (r_state == StRun) && (r_outstanding < CNT_W'(MAX_OUTSTANDING));
  assign o_tq_pop      = i_slv_reply_valid && (r_outstanding != '0);
  assign o_outstanding = r_outstanding;

  // Two passes: requesters at or above the pointer first, then the wrapped-around remainder.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!w_found && (PTR_W'(k) >= r_rr_ptr) && i_req_valid[k]) begin
        w_found = 1'b1;
        w_idx   = PTR_W'(k);
      end
    end
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!w_found && i_req_valid[k]) begin
        w_found = 1'b1;
        w_idx   = PTR_W'(k);
      end
    end
  end

  always_comb begin
    i_req_ready = '0;
    w_data      = '0;
    w_dst       = '0;
    w_vc        = '0;
    w_tag       = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (w_idx == PTR_W'(k)) begin
        i_req_ready[k] = w_can_grant && w_found;
        w_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        w_dst  = i_req_dst[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_vc   = i_req_vc[k*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
        w_tag  = i_req_tag[k*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign w_accept = |(i_req_valid & i_req_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= StRun;
      r_rr_ptr        <= '0;
      r_outstanding   <= '0;
      o_slv_valid     <= 1'b0;
      o_slv_data      <= '0;
      o_tq_push       <= 1'b0;
      o_tq_dst        <= '0;
      o_tq_vc         <= '0;
      o_tq_tag        <= '0;
      o_flush_done    <= 1'b0;
      o_err_underflow <= 1'b0;
    end else begin
      o_slv_valid  <= w_accept;
      o_tq_push    <= w_accept;
      o_flush_done <= 1'b0;
      if (w_accept) begin
        o_slv_data <= w_data;
        o_tq_dst   <= w_dst;
        o_tq_vc    <= w_vc;
        o_tq_tag   <= w_tag;
        r_rr_ptr   <= (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end

      unique case ({w_accept, o_tq_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (i_slv_reply_valid && (r_outstanding == '0)) begin
        o_err_underflow <= 1'b1;
      end

      // Drain completes only once the last forwarded request has also left the output stage.
      unique case (r_state)
        StRun: begin
          if (i_flush) r_state <= StDrain;
        end
        StDrain: begin
          if ((r_outstanding == '0) && !o_slv_valid) begin
            r_state      <= StRun;
            o_flush_done <= 1'b1;
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_reply_scheduler.sv
// Bench for slave_reply_scheduler: per-cycle comparison against a queue/credit model,
// plus directed scenarios with hand-computed expectations.
module tb_slave_reply_scheduler;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int VW  = 1;
  localparam int TW  = 8;
  localparam int MAX = 12;
  localparam int CW  = $clog2(MAX + 1);

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_data;
  logic [N*AW-1:0]   req_dst;
  logic [N*VW-1:0]   req_vc;
  logic [N*TW-1:0]   req_tag;
  logic              slv_valid;
  logic [DW-1:0]     slv_data;
  logic              tq_push;
  logic [AW-1:0]     tq_dst;
  logic [VW-1:0]     tq_vc;
  logic [TW-1:0]     tq_tag;
  logic              reply;
  logic              tq_pop;
  logic              flush;
  logic              flush_done;
  logic [CW-1:0]     outstanding;
  logic              err_uf;

  int errors = 0;
  int checks = 0;

  slave_reply_scheduler #(
    .N_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW),
    .TAG_WIDTH(TW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_ready(req_ready),
    .i_req_data(req_data), .i_req_dst(req_dst), .i_req_vc(req_vc), .i_req_tag(req_tag),
    .o_slv_valid(slv_valid), .o_slv_data(slv_data),
    .o_tq_push(tq_push), .o_tq_dst(tq_dst), .o_tq_vc(tq_vc), .o_tq_tag(tq_tag),
    .i_slv_reply_valid(reply), .o_tq_pop(tq_pop),
    .i_flush(flush), .o_flush_done(flush_done),
    .o_outstanding(outstanding), .o_err_underflow(err_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: credit count, pointer, drain flag and the last accepted request's fields.
  int          m_ptr, m_cnt, m_win;
  bit          m_drain, m_sv, m_done, m_err;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_dst;
  logic [VW-1:0] m_vc;
  logic [TW-1:0] m_tag;
  logic [N-1:0]  e_ready;
  bit            e_pop;
  int            cand;

  always @(negedge clk) begin
    if (!rst) begin
      m_ptr = 0; m_cnt = 0; m_drain = 0; m_sv = 0; m_done = 0; m_err = 0;
      m_data = '0; m_dst = '0; m_vc = '0; m_tag = '0;
    end
    m_win   = -1;
    e_ready = '0;
    if (!m_drain && m_cnt < MAX) begin
      for (int i = 0; i < N; i++) begin
        cand = (m_ptr + i) % N;
        if (m_win < 0 && req_valid[cand]) m_win = cand;
      end
      if (m_win >= 0) e_ready[m_win] = 1'b1;
    end
    e_pop = reply && (m_cnt > 0);

    chk("ready", req_ready, e_ready);
    chk("tq_pop", tq_pop, e_pop);
    chk("slv_valid", slv_valid, m_sv);
    chk("tq_push", tq_push, m_sv);
    chk("slv_data", slv_data, m_data);
    chk("tq_dst", tq_dst, m_dst);
    chk("tq_vc", tq_vc, m_vc);
    chk("tq_tag", tq_tag, m_tag);
    chk("flush_done", flush_done, m_done);
    chk("outstanding", outstanding, m_cnt);
    chk("err_underflow", err_uf, m_err);

    if (rst) begin
      if (m_drain) begin
        m_done = (m_cnt == 0) && !m_sv;
        if (m_done) m_drain = 0;
      end else begin
        m_done = 0;
        if (flush) m_drain = 1;
      end
      if (reply && m_cnt == 0) m_err = 1;
      m_cnt = m_cnt + (m_win >= 0 ? 1 : 0) - (e_pop ? 1 : 0);
      m_sv  = (m_win >= 0);
      if (m_win >= 0) begin
        m_data = req_data[m_win*DW +: DW];
        m_dst  = req_dst[m_win*AW +: AW];
        m_vc   = req_vc[m_win*VW +: VW];
        m_tag  = req_tag[m_win*TW +: TW];
        m_ptr  = (m_win + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  logic [TW-1:0] tags[$];

  initial begin
    for (int k = 0; k < N; k++) begin
      req_data[k*DW +: DW] = 32'hA000_0000 + k;
      req_dst[k*AW +: AW]  = AW'(k + 4);
      req_vc[k*VW +: VW]   = VW'(k & 1);
      req_tag[k*TW +: TW]  = TW'(8'h10 + k);
    end
    rst = 1'b0; req_valid = '0; reply = 1'b0; flush = 1'b0;
    #2;
    chk("reset_slv_valid", slv_valid, 1'b0);
    chk("reset_outstanding", outstanding, 0);
    repeat (2) step();
    rst = 1'b1;

    // All requesters valid, no replies: round-robin until credits run out.
    step();
    req_valid = 4'hF;
    for (int i = 0; i < 16; i++) begin
      look();
      if (tq_push) tags.push_back(tq_tag);
      step();
    end
    chk("push_count", tags.size(), 12);
    for (int j = 0; j < tags.size(); j++) chk("tag_order", tags[j], 8'h10 + (j % 4));
    look();
    chk("stall_outstanding", outstanding, 12);
    chk("stall_ready", req_ready, 4'b0000);

    // One reply frees one credit; the next grant is visible a cycle later.
    step();
    reply = 1'b1;
    look();
    chk("single_pop", tq_pop, 1'b1);
    chk("no_bypass_ready", req_ready, 4'b0000);
    step();
    reply = 1'b0;
    look();
    chk("after_pop_cnt", outstanding, 11);
    chk("regrant_ready", req_ready, 4'b0001);
    step();
    look();
    chk("refill_cnt", outstanding, 12);
    chk("refill_tag", tq_tag, 8'h10);

    // Drain to 5, then accept and reply in the same cycle.
    step();
    req_valid = '0;
    reply = 1'b1;
    repeat (7) step();
    reply = 1'b0;
    look();
    chk("cnt_five", outstanding, 5);
    step();
    req_valid = 4'b0001;
    reply = 1'b1;
    look();
    chk("same_cycle_ready", req_ready, 4'b0001);
    chk("same_cycle_pop", tq_pop, 1'b1);
    step();
    req_valid = '0;
    reply = 1'b0;
    look();
    chk("same_cycle_cnt", outstanding, 5);
    chk("same_cycle_push", tq_push, 1'b1);
    step();
    look();
    chk("push_once", tq_push, 1'b0);

    // Only requester 2 valid: granted every cycle regardless of pointer position.
    step();
    req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("solo_ready", req_ready, 4'b0100);
      step();
    end
    req_valid = '0;
    look();
    chk("solo_data", slv_data, 32'hA000_0002);
    chk("solo_cnt", outstanding, 8);

    // Flush with 3 outstanding.
    step();
    reply = 1'b1;
    repeat (5) step();
    reply = 1'b0;
    flush = 1'b1;
    look();
    chk("pre_flush_cnt", outstanding, 3);
    step();
    flush = 1'b0;
    req_valid = 4'hF;
    reply = 1'b1;
    look();
    chk("drain_ready", req_ready, 4'b0000);
    repeat (3) step();
    reply = 1'b0;
    look();
    chk("drain_empty_cnt", outstanding, 0);
    chk("drain_not_done", flush_done, 1'b0);
    chk("drain_still_blocked", req_ready, 4'b0000);
    step();
    look();
    chk("flush_done", flush_done, 1'b1);
    chk("resume_ready", req_ready, 4'b1000);
    step();
    req_valid = '0;
    look();
    chk("done_pulse_end", flush_done, 1'b0);
    chk("resume_tag", tq_tag, 8'h13);

    // Underflow: reply with nothing outstanding.
    step();
    reply = 1'b1;
    step();
    look();
    chk("underflow_no_pop", tq_pop, 1'b0);
    step();
    reply = 1'b0;
    look();
    chk("underflow_flag", err_uf, 1'b1);
    repeat (3) step();
    look();
    chk("underflow_sticky", err_uf, 1'b1);

    // Flush while already empty.
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    look();
    chk("empty_drain_cycle", flush_done, 1'b0);
    step();
    look();
    chk("empty_flush_done", flush_done, 1'b1);

    // Asynchronous reset in the middle of traffic.
    step();
    req_valid = 4'hF;
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_slv_valid", slv_valid, 1'b0);
    chk("arst_push", tq_push, 1'b0);
    chk("arst_cnt", outstanding, 0);
    chk("arst_err", err_uf, 1'b0);
    chk("arst_data", slv_data, 32'h0);
    chk("arst_tag", tq_tag, 8'h00);
    step();
    step();
    rst = 1'b1;
    repeat (4) step();
    req_valid = '0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
